// File: rtl/mem_stage_pkg.sv
// Shared MIPS decode constants, Tnew encodings and E/M register layout for the memory stage.
package mem_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;

  localparam logic [1:0] TNEW_0     = 2'd0;
  localparam logic [1:0] TNEW_1     = 2'd1;
  localparam logic [1:0] TNEW_2     = 2'd2;

  typedef enum logic [2:0] {
    LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU
  } ld_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rt;
    logic [31:0] alu;
    logic [31:0] hilo;
    logic [4:0]  wreg;
    logic        rwr;
    logic        bw;
    logic [1:0]  tnew;
  } em_reg_t;

  function automatic ld_type_e ld_decode(input logic [5:0] op);
    case (op)
      OP_LW:   return LD_W;
      OP_LH:   return LD_H;
      OP_LHU:  return LD_HU;
      OP_LB:   return LD_B;
      OP_LBU:  return LD_BU;
      default: return LD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_ext.sv
// Load extender: picks the addressed byte/halfword out of the DM word and sign/zero-extends it.
module mem_ext
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  ld_type_e    ld_type,
  output logic [31:0] ext
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  // lh/lhu only look at addr[1]; an odd halfword address reads the aligned half
  assign half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  always_comb begin
    ext = rdata;
    case (ld_type)
      LD_H:    ext = {{16{half[15]}}, half};
      LD_HU:   ext = {16'h0, half};
      LD_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ext = {24'h0, byte_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: E/M register, DM port drive (address, byte enables, lane-replicated
// store data), load extension and M-stage result/forwarding selection.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_PC,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_data_rt,
  input  logic [31:0] in_ALUout,
  input  logic [31:0] in_HI_LO,
  input  logic [4:0]  in_RegWreg,
  input  logic        in_RegWrite,
  input  logic [1:0]  in_Tnew,
  input  logic        in_bw,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_inst_addr,
  output logic [31:0] out_PC,
  output logic [31:0] out_instruction,
  output logic [31:0] out_RegWdata,
  output logic [31:0] M_fwd_data,
  output logic [4:0]  M_RegWreg,
  output logic        M_RegWrite,
  output logic [1:0]  M_Tnew,
  output logic        out_bw
);

  em_reg_t     em_q;
  logic [5:0]  op, funct;
  logic [1:0]  off;
  ld_type_e    ld_type;
  logic [31:0] ld_ext;
  logic        is_link, is_mf;

  // No enable: hazards are handled upstream by freezing D and bubbling E
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      em_q    <= '0;
      em_q.pc <= PC_RESET;
    end else begin
      em_q.pc    <= in_PC;
      em_q.instr <= in_instruction;
      em_q.rt    <= in_data_rt;
      em_q.alu   <= in_ALUout;
      em_q.hilo  <= in_HI_LO;
      em_q.wreg  <= in_RegWreg;
      em_q.rwr   <= in_RegWrite;
      em_q.bw    <= in_bw;
      em_q.tnew  <= (in_Tnew == TNEW_0) ? TNEW_0 : in_Tnew - 2'd1;
    end
  end

  assign op      = em_q.instr[31:26];
  assign funct   = em_q.instr[5:0];
  assign off     = em_q.alu[1:0];
  assign ld_type = ld_decode(op);

  // Misaligned stores leave byteen at zero: the write is silently dropped
  always_comb begin
    m_data_byteen = 4'b0000;
    m_data_wdata  = em_q.rt;
    case (op)
      OP_SW: if (off == 2'd0) m_data_byteen = 4'b1111;
      OP_SH: begin
        m_data_wdata = {2{em_q.rt[15:0]}};
        if (!off[0]) m_data_byteen = off[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        m_data_wdata  = {4{em_q.rt[7:0]}};
        m_data_byteen = 4'b0001 << off;
      end
      default: ;
    endcase
  end

  mem_ext u_ext (
    .addr    (off),
    .rdata   (m_data_rdata),
    .ld_type (ld_type),
    .ext     (ld_ext)
  );

  assign is_link = (op == OP_JAL) || (op == OP_SPECIAL && funct == FN_JALR);
  assign is_mf   = (op == OP_SPECIAL) && (funct == FN_MFHI || funct == FN_MFLO);

  always_comb begin
    M_fwd_data = em_q.alu;
    if (is_link)    M_fwd_data = em_q.pc + 32'd8;
    else if (is_mf) M_fwd_data = em_q.hilo;
  end

  assign out_RegWdata    = (ld_type != LD_NONE) ? ld_ext : M_fwd_data;
  assign m_data_addr     = em_q.alu;
  assign m_inst_addr     = em_q.pc;
  assign out_PC          = em_q.pc;
  assign out_instruction = em_q.instr;
  assign M_RegWreg       = em_q.wreg;
  assign M_RegWrite      = em_q.rwr;
  assign M_Tnew          = em_q.tnew;
  assign out_bw          = em_q.bw;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage against a behavioural model of the memory-stage rules.
module tb_mem_stage;

  localparam logic [31:0] PC_RST = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_PC, in_instruction, in_data_rt, in_ALUout, in_HI_LO;
  logic [4:0]  in_RegWreg;
  logic        in_RegWrite;
  logic [1:0]  in_Tnew;
  logic        in_bw;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] out_PC, out_instruction, out_RegWdata, M_fwd_data;
  logic [4:0]  M_RegWreg;
  logic        M_RegWrite, out_bw;
  logic [1:0]  M_Tnew;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .reset(reset),
    .in_PC(in_PC), .in_instruction(in_instruction), .in_data_rt(in_data_rt),
    .in_ALUout(in_ALUout), .in_HI_LO(in_HI_LO), .in_RegWreg(in_RegWreg),
    .in_RegWrite(in_RegWrite), .in_Tnew(in_Tnew), .in_bw(in_bw),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata), .m_inst_addr(m_inst_addr),
    .out_PC(out_PC), .out_instruction(out_instruction), .out_RegWdata(out_RegWdata),
    .M_fwd_data(M_fwd_data), .M_RegWreg(M_RegWreg), .M_RegWrite(M_RegWrite),
    .M_Tnew(M_Tnew), .out_bw(out_bw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int fn);
    logic [31:0] r;
    r = $urandom;
    r[31:26] = op[5:0];
    r[5:0]   = fn[5:0];
    return r;
  endfunction

  // Drive one Execute bundle, clock it into M, apply a DM read word, check every output.
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] rt,
                      input logic [31:0] alu, input logic [31:0] hilo, input logic [4:0] wreg,
                      input logic rwr, input logic [1:0] tnew, input logic bw,
                      input logic [31:0] rd);
    int op, fn, off, h, b;
    logic [31:0] e_fwd, e_res, e_wd;
    logic [3:0]  e_be;
    in_PC = pc; in_instruction = ins; in_data_rt = rt; in_ALUout = alu; in_HI_LO = hilo;
    in_RegWreg = wreg; in_RegWrite = rwr; in_Tnew = tnew; in_bw = bw;
    @(posedge clk);
    #1 m_data_rdata = rd;
    #1;
    op  = int'(ins[31:26]);
    fn  = int'(ins[5:0]);
    off = int'(alu % 4);
    e_be = 4'd0;
    e_wd = rt;
    if (op == 'h2b) e_be = (off == 0) ? 4'hf : 4'h0;
    if (op == 'h29) begin
      e_be = (off % 2 == 0) ? 4'(3 << off) : 4'h0;
      e_wd = (rt & 32'hffff) * 32'h0001_0001;
    end
    if (op == 'h28) begin
      e_be = 4'(1 << off);
      e_wd = (rt & 32'hff) * 32'h0101_0101;
    end
    if (op == 'h03 || (op == 0 && fn == 'h09)) e_fwd = pc + 8;
    else if (op == 0 && (fn == 'h10 || fn == 'h12)) e_fwd = hilo;
    else e_fwd = alu;
    h = int'((rd >> (16 * (off / 2))) & 32'hffff);
    b = int'((rd >> (8 * off)) & 32'hff);
    case (op)
      'h23: e_res = rd;
      'h21: e_res = (h >= 'h8000) ? (32'(h) | 32'hffff_0000) : 32'(h);
      'h25: e_res = 32'(h);
      'h20: e_res = (b >= 'h80) ? (32'(b) | 32'hffff_ff00) : 32'(b);
      'h24: e_res = 32'(b);
      default: e_res = e_fwd;
    endcase
    chk("addr",   m_data_addr, alu);
    chk("byteen", {28'd0, m_data_byteen}, {28'd0, e_be});
    if (op == 'h2b || op == 'h29 || op == 'h28) chk("wdata", m_data_wdata, e_wd);
    chk("inst_addr", m_inst_addr, pc);
    chk("out_pc", out_PC, pc);
    chk("out_instr", out_instruction, ins);
    chk("fwd", M_fwd_data, e_fwd);
    chk("regwdata", out_RegWdata, e_res);
    chk("wreg", {27'd0, M_RegWreg}, {27'd0, wreg});
    chk("regwrite", {31'd0, M_RegWrite}, {31'd0, rwr});
    chk("tnew", {30'd0, M_Tnew}, (tnew == 0) ? 32'd0 : 32'(tnew) - 32'd1);
    chk("bw", {31'd0, out_bw}, {31'd0, bw});
  endtask

  initial begin
    int ops[13];
    ops = '{'h23, 'h21, 'h25, 'h20, 'h24, 'h2b, 'h29, 'h28, 'h03, 0, 0, 0, 'h0f};
    reset = 1'b0;
    m_data_rdata = '0;
    in_PC = '0; in_instruction = '0; in_data_rt = '0; in_ALUout = '0; in_HI_LO = '0;
    in_RegWreg = '0; in_RegWrite = 1'b0; in_Tnew = '0; in_bw = 1'b0;
    #12;
    chk("rst_pc", m_inst_addr, PC_RST);
    chk("rst_instr", out_instruction, 32'd0);
    chk("rst_byteen", {28'd0, m_data_byteen}, 32'd0);
    chk("rst_regwrite", {31'd0, M_RegWrite}, 32'd0);
    chk("rst_tnew", {30'd0, M_Tnew}, 32'd0);
    chk("rst_result", out_RegWdata, 32'd0);
    reset = 1'b1;

    // directed cases
    step(32'h3000, mk('h2b, 0), 32'hDEAD_BEEF, 32'h10, 0, 5'd0, 0, 2'd0, 0, 0);
    chk("sw_be", {28'd0, m_data_byteen}, 32'hf);
    chk("sw_wd", m_data_wdata, 32'hDEAD_BEEF);
    step(32'h3004, mk('h28, 0), 32'hA5, 32'h13, 0, 5'd0, 0, 2'd0, 0, 0);
    chk("sb_be", {28'd0, m_data_byteen}, 32'h8);
    chk("sb_wd", m_data_wdata, 32'hA5A5_A5A5);
    step(32'h3008, mk('h29, 0), 32'h1234, 32'h11, 0, 5'd0, 0, 2'd0, 0, 0);
    chk("sh_mis_be", {28'd0, m_data_byteen}, 32'h0);
    step(32'h300c, mk('h21, 0), 0, 32'h22, 0, 5'd8, 1, 2'd2, 0, 32'h8001_1234);
    chk("lh", out_RegWdata, 32'hFFFF_8001);
    chk("ld_tnew", {30'd0, M_Tnew}, 32'd1);
    step(32'h3010, mk('h25, 0), 0, 32'h22, 0, 5'd8, 1, 2'd2, 0, 32'h8001_1234);
    chk("lhu", out_RegWdata, 32'h0000_8001);
    step(32'h3014, mk('h24, 0), 0, 32'h23, 0, 5'd8, 1, 2'd2, 0, 32'h8001_1234);
    chk("lbu", out_RegWdata, 32'h0000_0080);
    step(32'h3004, mk('h03, 0), 0, 32'h55, 0, 5'd31, 1, 2'd0, 1, 0);
    chk("jal_fwd", M_fwd_data, 32'h300C);

    // asynchronous reset in the middle of a store cycle
    step(32'h3020, mk('h2b, 0), 32'h1, 32'h40, 0, 5'd0, 1, 2'd1, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_byteen", {28'd0, m_data_byteen}, 32'd0);
    chk("arst_regwrite", {31'd0, M_RegWrite}, 32'd0);
    chk("arst_pc", m_inst_addr, PC_RST);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("arst_hold", m_inst_addr, PC_RST);

    for (int i = 0; i < 400; i++) begin
      int op;
      int fn;
      logic [31:0] a;
      op = ops[$urandom_range(0, 12)];
      fn = (op == 0) ? int'($urandom_range(0, 3) == 0 ? 'h09 : ($urandom_range(0, 1) ? 'h10 : 'h12))
                     : int'($urandom_range(0, 63));
      a = $urandom;
      step($urandom, mk(op, fn), $urandom, a, $urandom, 5'($urandom), 1'($urandom),
           2'($urandom_range(0, 2)), 1'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
